// File: rtl/clk_enable_gen_multi.sv
// Multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle enable pulse every div[ch] system clocks.
// Divisors can be reloaded at run time through a single write port.
// No derived clocks: every output is a registered enable on the system clock.
module clk_enable_gen_multi #(
   parameter int unsigned SYS_CLOCK   = 5000000,
   parameter int unsigned DES_CLOCK   = 1000,
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CH_W        = 2,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = SYS_CLOCK / DES_CLOCK
) (
   input  logic              clock,
   input  logic              greset,
   input  logic              run,
   input  logic [N_CH-1:0]   ch_en,
   input  logic              sync_clr,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   output logic [N_CH-1:0]   enable,
   output logic              all_tick
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [CNT_W-1:0] div_q [N_CH];
   logic [CNT_W-1:0] div_d [N_CH];
   logic [N_CH-1:0]  pulse_d;
   logic [N_CH-1:0]  active;
   logic [N_CH-1:0]  wr_hit;
   logic             wr_valid;
   logic             all_tick_d;

   // Decode the write strobe; a channel index outside the build is dropped.
   always_comb begin
      wr_valid = wr_en && (32'(wr_ch) < N_CH);
      for (int unsigned i = 0; i < N_CH; i++) begin
         wr_hit[i] = wr_valid && (32'(wr_ch) == i);
      end
   end

   // Per-channel next count, divisor and pulse; write beats clear beats counting.
   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         div_d[i]   = div_q[i];
         cnt_d[i]   = cnt_q[i];
         pulse_d[i] = 1'b0;
         active[i]  = run && ch_en[i] && (div_q[i] != '0);
         if (wr_hit[i]) begin
            div_d[i] = wr_div;
            cnt_d[i] = '0;
         end else if (sync_clr) begin
            cnt_d[i] = '0;
         end else if (!run) begin
            // Frozen: hold the phase so counting resumes where it stopped.
            cnt_d[i] = cnt_q[i];
         end else if (!active[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Phase-alignment marker: every active channel pulses on the same edge.
   always_comb begin
      all_tick_d = (|active) && (&(pulse_d | ~active));
   end

   // State and registered outputs, cleared asynchronously by greset.
   always_ff @(posedge clock or posedge greset) begin
      if (greset) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= DIV_RST;
         end
         enable   <= '0;
         all_tick <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            div_q[i] <= div_d[i];
         end
         enable   <= pulse_d;
         all_tick <= all_tick_d;
      end
   end

endmodule

// File: tb/tb_clk_enable_gen_multi.sv
// Self-checking bench for clk_enable_gen_multi: a 4-channel and a 3-channel build
// share stimulus and are compared every cycle against an elapsed-clock model.
module tb_clk_enable_gen_multi;

   logic       clock    = 1'b0;
   logic       greset   = 1'b1;
   logic       run      = 1'b0;
   logic       sync_clr = 1'b0;
   logic       wr_en    = 1'b0;
   logic [3:0] ch_en    = 4'b0000;
   logic [1:0] wr_ch    = 2'd0;
   logic [7:0] wr_div   = 8'd0;

   logic [3:0] enable;
   logic       all_tick;
   logic [2:0] enable3;
   logic       all_tick3;

   int errors = 0;
   int checks = 0;

   // Model: per build/channel, divisor and active clocks elapsed since the last restart.
   int         mdiv [2][4];
   int         mel  [2][4];
   logic [3:0] men  [2];
   logic       mall [2];

   always #5 clock = ~clock;

   clk_enable_gen_multi #(
      .SYS_CLOCK(10), .DES_CLOCK(1), .N_CH(4), .CH_W(2), .CNT_W(8)
   ) dut (
      .clock(clock), .greset(greset), .run(run), .ch_en(ch_en), .sync_clr(sync_clr),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .enable(enable), .all_tick(all_tick)
   );

   clk_enable_gen_multi #(
      .SYS_CLOCK(10), .DES_CLOCK(1), .N_CH(3), .CH_W(2), .CNT_W(8)
   ) dut3 (
      .clock(clock), .greset(greset), .run(run), .ch_en(ch_en[2:0]), .sync_clr(sync_clr),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .enable(enable3), .all_tick(all_tick3)
   );

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            mdiv[d][i] = 10;
            mel[d][i]  = 0;
         end
         men[d]  = 4'b0000;
         mall[d] = 1'b0;
      end
   endtask

   // A channel pulses when its elapsed active-clock count reaches a multiple of its divisor.
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int   nch;
         logic any_act;
         logic all_ok;
         nch     = (d == 0) ? 4 : 3;
         any_act = 1'b0;
         all_ok  = 1'b1;
         men[d]  = 4'b0000;
         for (int i = 0; i < nch; i++) begin
            logic act;
            logic p;
            act = run && ch_en[i] && (mdiv[d][i] != 0);
            p   = 1'b0;
            if (wr_en && (int'(wr_ch) == i)) begin
               mdiv[d][i] = int'(wr_div);
               mel[d][i]  = 0;
            end else if (sync_clr) begin
               mel[d][i] = 0;
            end else if (!run) begin
               // elapsed count frozen
            end else if (!act) begin
               mel[d][i] = 0;
            end else begin
               mel[d][i] = mel[d][i] + 1;
               p = ((mel[d][i] % mdiv[d][i]) == 0);
            end
            men[d][i] = p;
            if (act) begin
               any_act = 1'b1;
               if (!p) all_ok = 1'b0;
            end
         end
         mall[d] = any_act && all_ok;
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock with the current inputs, then compare both builds to the model.
   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      check("enable4", enable, men[0]);
      check("all_tick4", {3'b000, all_tick}, {3'b000, mall[0]});
      check("enable3", {1'b0, enable3}, men[1]);
      check("all_tick3", {3'b000, all_tick3}, {3'b000, mall[1]});
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic write(input logic [1:0] ch, input logic [7:0] dv);
      wr_en  = 1'b1;
      wr_ch  = ch;
      wr_div = dv;
      tick();
      wr_en  = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      check("reset_enable", enable, 4'b0000);
      check("reset_all_tick", {3'b000, all_tick}, 4'b0000);
      greset = 1'b0;

      // Default divisor 10 on channel 0: pulses on clocks 10, 20, 30.
      run   = 1'b1;
      ch_en = 4'b0001;
      for (int c = 1; c <= 30; c++) begin
         tick();
         check("t1_pulse", enable, (c % 10 == 0) ? 4'b0001 : 4'b0000);
      end

      // Channels 1 and 2 at divisors 3 and 6, aligned by a sync clear.
      write(2'd1, 8'd3);
      write(2'd2, 8'd6);
      ch_en    = 4'b0110;
      sync_clr = 1'b1;
      tick();
      sync_clr = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         tick();
         check("t2_all_tick", {3'b000, all_tick}, (c % 6 == 0) ? 4'b0001 : 4'b0000);
      end

      // Divisor 1 holds enable high; divisor 0 turns the channel off.
      ch_en = 4'b0001;
      write(2'd0, 8'd1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("t3_div1", enable, 4'b0001);
      end
      write(2'd0, 8'd0);
      ticks(4);
      check("t3_div0", enable, 4'b0000);

      // Freezing run mid-count delays the pulse by the frozen clocks.
      write(2'd0, 8'd10);
      ticks(5);
      run = 1'b0;
      ticks(4);
      run = 1'b1;
      ticks(4);
      check("t4_before", enable, 4'b0000);
      tick();
      check("t4_delayed", enable, 4'b0001);

      // Reload mid-count restarts the phase; channel 3 write is dropped by the 3-channel build.
      ticks(7);
      write(2'd0, 8'd4);
      ticks(3);
      check("t5_early", enable, 4'b0000);
      tick();
      check("t5_reload", enable, 4'b0001);
      ch_en = 4'b1111;
      write(2'd3, 8'd2);
      ticks(12);

      // Asynchronous reset between edges clears outputs immediately.
      ch_en = 4'b0001;
      write(2'd0, 8'd1);
      ticks(3);
      #2;
      greset = 1'b1;
      #1;
      check("t6_async_enable", enable, 4'b0000);
      check("t6_async_all_tick", {3'b000, all_tick}, 4'b0000);
      model_reset();
      @(posedge clock);
      #1;
      greset = 1'b0;
      ticks(9);
      check("t6_no_early", enable, 4'b0000);
      tick();
      check("t6_default_div", enable, 4'b0001);

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         run      = ($urandom % 20) != 0;
         sync_clr = ($urandom % 60) == 0;
         if (($urandom % 40) == 0) ch_en = 4'($urandom);
         wr_en  = ($urandom % 15) == 0;
         wr_ch  = 2'($urandom);
         wr_div = (($urandom % 8) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
         tick();
      end
      wr_en    = 1'b0;
      sync_clr = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
